timer_digit_entry: RTL and testbench
====================================

Name: timer_digit_entry

Overview:
- Sequential receiver for the keypad coder's output (`data[3:0]` plus `valid_input`, where `valid_input` is level-high while any key is held).
- Debounces each press and accepts exactly one digit per press.
- Shifts accepted digits into a 4-digit BCD MM:SS entry buffer, oven-keypad style.
- Hands the entered time to the countdown timer through a valid/ready handshake.
- Sits between the keypad coder and the timer block in the TimerInput level.

Parameters:
- DEBOUNCE_CYCLES, default 4, number of consecutive stable clock cycles required to qualify a press and a release. The top level overrides it with the board value.
- CNT_W, default 3, width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data`  input  4  digit code from the keypad coder.
- `valid_input`  input  1  high while any key is held.
- `clear`  input  1  cancel key, level; clears the buffer.
- `load_req`  input  1  start key, single-cycle pulse; requests handoff of the entered time.
- `time_out_ready`  input  1  timer accepts the handed-off time.
- `time_bcd`  output  16  live buffer: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
- `digit_count`  output  3  number of digits entered, 0..4.
- `key_accepted`  output  1  one-cycle pulse when a digit is shifted in.
- `key_rejected`  output  1  one-cycle pulse when a qualified press is discarded.
- `time_out`  output  16  BCD time held stable for the handoff.
- `time_out_valid`  output  1  handoff pending.

Behaviour:
- Reset: all registers, including every output, go to 0; the debounce FSM goes to IDLE.
- Debounce FSM, driven by `valid_input`:
  - IDLE: when `valid_input`=1, go to PRESS_DB and clear the counter.
  - PRESS_DB: if `valid_input` drops, return to IDLE. Otherwise count; when the counter reaches DEBOUNCE_CYCLES-1, go to HELD, sample `data`, and issue a qualified press that same cycle.
  - HELD: when `valid_input`=0, go to REL_DB and clear the counter.
  - REL_DB: if `valid_input` rises again, return to HELD. Otherwise count; at DEBOUNCE_CYCLES-1, go to IDLE.
  - A press therefore qualifies DEBOUNCE_CYCLES cycles after `valid_input` rises. A held key produces exactly one qualified press, and bounces shorter than DEBOUNCE_CYCLES are ignored.
- Qualified press handling:
  - The digit is accepted only if `data`≤9, `digit_count`<4, `time_out_valid`=0 and `clear`=0.
  - Accept: shift left by one nibble (old [15:12] discarded), new digit into [3:0], `digit_count`+1, `key_accepted`=1 for one cycle.
  - Any other qualified press: buffer unchanged, `key_rejected`=1 for one cycle. The only exception is `clear`=1, where no pulse is issued.
  - Leading zero keys are accepted and counted.
- `clear`=1: next cycle `time_bcd`=0 and `digit_count`=0. It also drops a pending `time_out_valid` (`time_out` → 0). Clear wins over a simultaneous accept, load or handshake.
- Load:
  - `load_req`=1 with `digit_count`>0, `time_out_valid`=0 and `clear`=0: next cycle `time_out`=`time_bcd` and `time_out_valid`=1.
  - `load_req` with `digit_count`=0, or while a handoff is already pending, is ignored.
  - `time_out` is held stable while `time_out_valid`=1.
  - Handshake: the cycle where `time_out_valid`&`time_out_ready`=1 completes the transfer. Next cycle `time_out_valid`=0, `time_bcd`=0, `digit_count`=0.
  - `time_out_ready` with `time_out_valid`=0 has no effect.
- Same-cycle priority: `reset` > `clear` > handshake completion > `load_req` > key accept. A qualified press in the same cycle as `load_req` is rejected, because the load takes priority.
- No seconds normalisation: 0:90 passes through unchanged; the timer handles conversion.
- Reset mid-press: the FSM returns to IDLE. A key still held after reset is re-qualified as a new press.

Decomposition:
- Shared package: FSM state encoding (IDLE, PRESS_DB, HELD, REL_DB), BCD nibble field positions, the MAX_DIGITS=4 constant and the digit-code width 4.
- One sub-module, `key_debouncer`: the FSM plus counter. It takes `clk`, `reset`, `valid_input` and `data`, and produces a qualified-press pulse and the sampled digit.
- The shift buffer and load handshake stay in the top.

Test Plan:
- Press 1, 2, 3, 0, each held 10 cycles with 10-cycle gaps → `key_accepted` pulses 4 times; `time_bcd`=16'h1230, `digit_count`=4.
- Fifth press 7 after the above → `key_rejected` pulse; `time_bcd` stays 16'h1230.
- `valid_input` toggling with 2-cycle glitches then held 20 cycles with digit 5 (DEBOUNCE_CYCLES=4) → exactly one accept, `time_bcd`=16'h0005.
- Enter 4, 5; pulse `load_req`; hold `time_out_ready`=0 for 5 cycles, then 1 → `time_out`=16'h0045 stable with valid=1 throughout. The cycle after the handshake: valid=0, `time_bcd`=0, `digit_count`=0. A key pressed while pending is rejected.
- `load_req` with an empty buffer → `time_out_valid` stays 0. `clear` asserted in the same cycle as a qualified press of 9 → buffer 0, no pulses.
- Assert `reset` during PRESS_DB with the key still held → outputs 0, then one accept about DEBOUNCE_CYCLES cycles after reset deasserts.

Source files
------------

// File: rtl/timer_digit_entry_pkg.sv
// Shared definitions for the keypad digit-entry block: debounce FSM states,
// BCD buffer layout and digit limits.
package timer_digit_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } db_state_t;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 4;
  localparam int BCD_W      = DIGIT_W * MAX_DIGITS;

  // Nibble positions inside the MM:SS buffer
  localparam int MIN_TENS_LSB = 12;
  localparam int MIN_ONES_LSB = 8;
  localparam int SEC_TENS_LSB = 4;
  localparam int SEC_ONES_LSB = 0;

  localparam logic [DIGIT_W-1:0] MAX_BCD_DIGIT = 4'd9;

  // Oven-keypad entry: existing digits move one place left, newest lands in seconds-ones.
  function automatic logic [BCD_W-1:0] shift_in_digit(input logic [BCD_W-1:0] bcd,
                                                      input logic [DIGIT_W-1:0] digit);
    logic [BCD_W-1:0] result;
    result = '0;
    result[MIN_TENS_LSB +: DIGIT_W] = bcd[MIN_ONES_LSB +: DIGIT_W];
    result[MIN_ONES_LSB +: DIGIT_W] = bcd[SEC_TENS_LSB +: DIGIT_W];
    result[SEC_TENS_LSB +: DIGIT_W] = bcd[SEC_ONES_LSB +: DIGIT_W];
    result[SEC_ONES_LSB +: DIGIT_W] = digit;
    return result;
  endfunction

endpackage

// File: rtl/timer_digit_entry_key_debouncer.sv
// Press/release debouncer: qualifies each key press exactly once after the
// level has been stable, and ignores bounces shorter than the debounce window.
module key_debouncer
  import timer_digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_input,
  input  logic [DIGIT_W-1:0] data,
  output logic               press,
  output logic [DIGIT_W-1:0] digit
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (valid_input) begin
          state_next = ST_PRESS_DB;
          cnt_next   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!valid_input)            state_next = ST_IDLE;
        else if (cnt_reg == CNT_LAST) state_next = ST_HELD;
        else                          cnt_next   = cnt_reg + CNT_W'(1);
      end
      ST_HELD: begin
        if (!valid_input) begin
          state_next = ST_REL_DB;
          cnt_next   = '0;
        end
      end
      ST_REL_DB: begin
        if (valid_input)              state_next = ST_HELD;
        else if (cnt_reg == CNT_LAST) state_next = ST_IDLE;
        else                          cnt_next   = cnt_reg + CNT_W'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The press is reported on the same cycle the FSM moves into HELD, with the
  // digit code captured from that cycle's data.
  always_comb begin
    press = (state_reg == ST_PRESS_DB) && valid_input && (cnt_reg == CNT_LAST);
    digit = press ? data : '0;
  end

endmodule

// File: rtl/timer_digit_entry.sv
// Keypad digit entry: debounced digits shift into an MM:SS BCD buffer which is
// handed to the countdown timer through a valid/ready handshake.
module timer_digit_entry
  import timer_digit_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] data,
  input  logic               valid_input,
  input  logic               clear,
  input  logic               load_req,
  input  logic               time_out_ready,
  output logic [BCD_W-1:0]   time_bcd,
  output logic [2:0]         digit_count,
  output logic               key_accepted,
  output logic               key_rejected,
  output logic [BCD_W-1:0]   time_out,
  output logic               time_out_valid
);

  logic               press;
  logic [DIGIT_W-1:0] press_digit;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .valid_input(valid_input),
    .data       (data),
    .press      (press),
    .digit      (press_digit)
  );

  logic [BCD_W-1:0] time_bcd_reg, time_bcd_next;
  logic [2:0]       digit_count_reg, digit_count_next;
  logic             key_accepted_reg, key_accepted_next;
  logic             key_rejected_reg, key_rejected_next;
  logic [BCD_W-1:0] time_out_reg, time_out_next;
  logic             time_out_valid_reg, time_out_valid_next;

  logic handshake, load_take, digit_ok;

  always_comb begin
    handshake = time_out_valid_reg && time_out_ready;
    load_take = load_req && (digit_count_reg != 3'd0) && !time_out_valid_reg;
    digit_ok  = (press_digit <= MAX_BCD_DIGIT) && (digit_count_reg < 3'(MAX_DIGITS))
                && !time_out_valid_reg && !load_take;
  end

  always_comb begin
    time_bcd_next       = time_bcd_reg;
    digit_count_next    = digit_count_reg;
    key_accepted_next   = 1'b0;
    key_rejected_next   = 1'b0;
    time_out_next       = time_out_reg;
    time_out_valid_next = time_out_valid_reg;

    if (clear) begin
      time_bcd_next       = '0;
      digit_count_next    = '0;
      time_out_next       = '0;
      time_out_valid_next = 1'b0;
    end else begin
      if (handshake) begin
        time_out_valid_next = 1'b0;
        time_bcd_next       = '0;
        digit_count_next    = '0;
      end else if (load_take) begin
        time_out_next       = time_bcd_reg;
        time_out_valid_next = 1'b1;
      end
      // A press during a pending handoff or a taken load is always rejected.
      if (press) begin
        if (digit_ok) begin
          time_bcd_next     = shift_in_digit(time_bcd_reg, press_digit);
          digit_count_next  = digit_count_reg + 3'd1;
          key_accepted_next = 1'b1;
        end else begin
          key_rejected_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_bcd_reg       <= '0;
      digit_count_reg    <= '0;
      key_accepted_reg   <= 1'b0;
      key_rejected_reg   <= 1'b0;
      time_out_reg       <= '0;
      time_out_valid_reg <= 1'b0;
    end else begin
      time_bcd_reg       <= time_bcd_next;
      digit_count_reg    <= digit_count_next;
      key_accepted_reg   <= key_accepted_next;
      key_rejected_reg   <= key_rejected_next;
      time_out_reg       <= time_out_next;
      time_out_valid_reg <= time_out_valid_next;
    end
  end

  assign time_bcd       = time_bcd_reg;
  assign digit_count    = digit_count_reg;
  assign key_accepted   = key_accepted_reg;
  assign key_rejected   = key_rejected_reg;
  assign time_out       = time_out_reg;
  assign time_out_valid = time_out_valid_reg;

endmodule

// File: tb/tb_timer_digit_entry.sv
// Self-checking bench for timer_digit_entry: per-cycle reference model,
// a table of key presses, directed corner sequences and a random phase.
module tb_timer_digit_entry;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  data = 4'd0;
  logic        valid_input = 1'b0;
  logic        clear = 1'b0;
  logic        load_req = 1'b0;
  logic        time_out_ready = 1'b0;
  logic [15:0] time_bcd;
  logic [2:0]  digit_count;
  logic        key_accepted;
  logic        key_rejected;
  logic [15:0] time_out;
  logic        time_out_valid;

  always #5 clk = ~clk;

  timer_digit_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .data          (data),
    .valid_input   (valid_input),
    .clear         (clear),
    .load_req      (load_req),
    .time_out_ready(time_out_ready),
    .time_bcd      (time_bcd),
    .digit_count   (digit_count),
    .key_accepted  (key_accepted),
    .key_rejected  (key_rejected),
    .time_out      (time_out),
    .time_out_valid(time_out_valid)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: entered digits kept as a plain list, press detection by
  // run lengths of the key level (a press needs D+1 high samples while armed,
  // re-arming needs D+1 low samples).
  int m_digits[$];
  int m_to = 0;
  int m_tov = 0;
  int m_acc = 0;
  int m_rej = 0;
  bit armed = 1'b1;
  int high_run = 0;
  int low_run = 0;

  function automatic int m_bcd();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit press_q;
    bit load_take;
    int d;
    if (reset) begin
      m_digits.delete();
      m_to = 0; m_tov = 0; m_acc = 0; m_rej = 0;
      armed = 1'b1; high_run = 0; low_run = 0;
      return;
    end
    press_q = 1'b0;
    if (valid_input) begin
      high_run++; low_run = 0;
      if (armed && high_run == D + 1) begin
        press_q = 1'b1;
        armed = 1'b0;
      end
    end else begin
      low_run++; high_run = 0;
      if (!armed && low_run == D + 1) armed = 1'b1;
    end
    d = int'(data);
    m_acc = 0; m_rej = 0;
    if (clear) begin
      m_digits.delete();
      m_to = 0; m_tov = 0;
    end else begin
      load_take = load_req && m_digits.size() > 0 && m_tov == 0;
      if (press_q) begin
        if (d <= 9 && m_digits.size() < 4 && m_tov == 0 && !load_take) begin
          m_digits.push_back(d);
          m_acc = 1;
        end else begin
          m_rej = 1;
        end
      end
      if (m_tov != 0 && time_out_ready) begin
        m_tov = 0;
        m_digits.delete();
      end else if (load_take) begin
        m_to = m_bcd();
        m_tov = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("time_bcd", int'(time_bcd), m_bcd());
    check("digit_count", int'(digit_count), m_digits.size());
    check("key_accepted", int'(key_accepted), m_acc);
    check("key_rejected", int'(key_rejected), m_rej);
    check("time_out", int'(time_out), m_to);
    check("time_out_valid", int'(time_out_valid), m_tov);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  task automatic press_key(input logic [3:0] d, input int hold, input int gap,
                           output int acc_n, output int rej_n);
    acc_n = 0; rej_n = 0;
    data = d; valid_input = 1'b1;
    repeat (hold) begin
      cycle();
      acc_n += int'(key_accepted); rej_n += int'(key_rejected);
    end
    valid_input = 1'b0;
    repeat (gap) begin
      cycle();
      acc_n += int'(key_accepted); rej_n += int'(key_rejected);
    end
  endtask

  typedef struct {
    logic [3:0]  digit;
    int          acc;
    int          rej;
    logic [15:0] bcd;
    logic [2:0]  cnt;
  } press_vec_t;

  press_vec_t tbl[5];

  initial begin
    int a, r, lat, seg_left;
    bit found;

    tbl[0] = '{4'd1, 1, 0, 16'h0001, 3'd1};
    tbl[1] = '{4'd2, 1, 0, 16'h0012, 3'd2};
    tbl[2] = '{4'd3, 1, 0, 16'h0123, 3'd3};
    tbl[3] = '{4'd0, 1, 0, 16'h1230, 3'd4};
    tbl[4] = '{4'd7, 0, 1, 16'h1230, 3'd4};

    reset_dut();
    check("reset_bcd", int'(time_bcd), 0);
    check("reset_valid", int'(time_out_valid), 0);

    // Table of presses: four accepted digits, fifth rejected when full
    for (int i = 0; i < 5; i++) begin
      press_key(tbl[i].digit, 10, 10, a, r);
      check("tbl_accepts", a, tbl[i].acc);
      check("tbl_rejects", r, tbl[i].rej);
      check("tbl_bcd", int'(time_bcd), int'(tbl[i].bcd));
      check("tbl_count", int'(digit_count), int'(tbl[i].cnt));
      $display("press %0d: acc=%0d rej=%0d bcd=%h count=%0d", tbl[i].digit, a, r,
               time_bcd, digit_count);
    end

    // Short glitches then a long hold give exactly one accept
    reset_dut();
    data = 4'd5;
    a = 0;
    repeat (3) begin
      valid_input = 1'b1; repeat (2) begin cycle(); a += int'(key_accepted); end
      valid_input = 1'b0; repeat (2) begin cycle(); a += int'(key_accepted); end
    end
    press_key(4'd5, 20, 10, lat, r);
    check("glitch_accepts", a + lat, 1);
    check("glitch_bcd", int'(time_bcd), 16'h0005);
    $display("glitch press: accepts=%0d bcd=%h", a + lat, time_bcd);

    // Load and held handoff, press while pending, handshake
    reset_dut();
    press_key(4'd4, 10, 10, a, r);
    press_key(4'd5, 10, 10, a, r);
    load_req = 1'b1; cycle(); load_req = 1'b0;
    check("load_valid", int'(time_out_valid), 1);
    check("load_time_out", int'(time_out), 16'h0045);
    repeat (5) begin
      cycle();
      check("pending_valid", int'(time_out_valid), 1);
      check("pending_time_out", int'(time_out), 16'h0045);
    end
    press_key(4'd8, 10, 10, a, r);
    check("pending_press_rej", r, 1);
    check("pending_press_acc", a, 0);
    time_out_ready = 1'b1; cycle(); time_out_ready = 1'b0;
    check("hs_valid", int'(time_out_valid), 0);
    check("hs_bcd", int'(time_bcd), 0);
    check("hs_count", int'(digit_count), 0);
    $display("handoff: time_out=%h valid=%0d bcd=%h", time_out, time_out_valid, time_bcd);

    // Load with empty buffer is ignored
    load_req = 1'b1; cycle(); load_req = 1'b0;
    check("empty_load_valid", int'(time_out_valid), 0);
    $display("empty load: valid=%0d", time_out_valid);

    // Clear on the qualifying cycle of a press of 9
    press_key(4'd2, 10, 10, a, r);
    data = 4'd9; valid_input = 1'b1;
    repeat (D) cycle();
    clear = 1'b1; cycle(); clear = 1'b0;
    check("clr_acc", int'(key_accepted), 0);
    check("clr_rej", int'(key_rejected), 0);
    check("clr_bcd", int'(time_bcd), 0);
    check("clr_count", int'(digit_count), 0);
    valid_input = 1'b0; repeat (10) cycle();
    $display("clear+press: bcd=%h count=%0d", time_bcd, digit_count);

    // Reset while a key is being debounced, key still held afterwards
    press_key(4'd3, 10, 10, a, r);
    data = 4'd6; valid_input = 1'b1;
    repeat (3) cycle();
    reset = 1'b1; cycle();
    check("rst_bcd", int'(time_bcd), 0);
    check("rst_count", int'(digit_count), 0);
    reset = 1'b0;
    lat = 0; found = 1'b0;
    while (!found && lat < 20) begin
      cycle();
      lat++;
      if (key_accepted) found = 1'b1;
    end
    check("rst_found_accept", int'(found), 1);
    check("rst_latency", lat, D + 1);
    check("rst_bcd_after", int'(time_bcd), 16'h0006);
    valid_input = 1'b0; repeat (10) cycle();
    $display("reset mid-press: accept latency=%0d bcd=%h", lat, time_bcd);

    // Random phase against the model
    reset_dut();
    seg_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg_left == 0) begin
        valid_input = ($urandom_range(0, 1) == 1);
        seg_left = $urandom_range(1, 12);
        if (valid_input) data = 4'($urandom_range(0, 11));
      end
      seg_left--;
      clear          = ($urandom_range(0, 99) < 2);
      load_req       = ($urandom_range(0, 99) < 6);
      time_out_ready = ($urandom_range(0, 99) < 30);
      reset          = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0; clear = 1'b0; load_req = 1'b0; time_out_ready = 1'b0; valid_input = 1'b0;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
